// File: rtl/neat_pkg.sv
// Shared definitions for the NEAT evaluation datapath: gene word layout and
// sequencer state encoding.
package neat_pkg;

  localparam int unsigned NEAT_NODE_W = 8;
  localparam int unsigned NEAT_WGT_W  = 16;
  localparam int unsigned NEAT_GENE_W = 2 * NEAT_NODE_W + NEAT_WGT_W + 1;

  // Gene word, MSB first: {enable, in_node, out_node, weight}
  typedef struct packed {
    logic                   enable;
    logic [NEAT_NODE_W-1:0] in_node;
    logic [NEAT_NODE_W-1:0] out_node;
    logic [NEAT_WGT_W-1:0]  weight;
  } gene_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/neat_gene_fifo.sv
// Synchronous FIFO with registered occupancy count and empty/full flags.
// Pushes into a full buffer (without a simultaneous pop) are dropped.
module neat_gene_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);

  // Pointer wrap and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/neat_gene_sequencer.sv
// Walks the genome memory on start, unpacks each connection gene and streams
// it downstream over valid/ready, optionally dropping disabled genes.
module neat_gene_sequencer
  import neat_pkg::*;
#(
  parameter int unsigned IDX_W         = 8,
  parameter int unsigned NODE_W        = NEAT_NODE_W,
  parameter int unsigned WGT_W         = NEAT_WGT_W,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          SKIP_DISABLED = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IDX_W:0]              num_genes,
  input  logic                        abort,
  output logic                        mem_rd_en,
  output logic [IDX_W-1:0]            mem_rd_addr,
  input  logic [2*NODE_W+WGT_W:0]     mem_rd_data,
  output logic                        gene_valid,
  input  logic                        gene_ready,
  output logic [NODE_W-1:0]           gene_in_node,
  output logic [NODE_W-1:0]           gene_out_node,
  output logic [WGT_W-1:0]            gene_weight,
  output logic                        gene_enable,
  output logic                        busy,
  output logic                        done,
  output logic [IDX_W:0]              emitted
);

  localparam int unsigned GENE_W = 2 * NODE_W + WGT_W + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W:0]   IDX_ONE   = (IDX_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  seq_state_e       state_q, state_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [IDX_W:0]   issue_q, issue_d;
  logic [IDX_W:0]   emitted_q, emitted_d;
  logic             inflight_q, inflight_d;

  logic             start_ok;
  logic             push;
  logic             pop;
  logic             fifo_flush;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [GENE_W-1:0] fifo_head;
  logic [GENE_W-1:0] head;
  logic [CNT_W:0]   credit_used;
  logic             has_credit;
  logic             more_to_issue;
  logic             last_issue;
  logic             empty_next;

  assign start_ok      = (state_q == ST_IDLE) && start && !abort;
  assign more_to_issue = (issue_q < num_q);
  assign last_issue    = ((issue_q + IDX_ONE) == num_q);
  assign credit_used   = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight_q);
  assign has_credit    = !fifo_full && (credit_used < CREDIT_MAX);

  assign push       = inflight_q && !abort && (!SKIP_DISABLED || mem_rd_data[GENE_W-1]);
  assign pop        = !fifo_empty && gene_ready && !abort;
  assign fifo_flush = rst || abort;

  // Buffer is empty after this edge: only meaningful once no return is pending
  assign empty_next = fifo_empty || ((fifo_count == CNT_ONE) && pop);

  neat_gene_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (GENE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (fifo_flush),
    .push      (push),
    .push_data (mem_rd_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN looks one edge ahead so done lands right after the last pop
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (num_genes == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (mem_rd_en && last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && empty_next) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  // FSM outputs: read strobe from registered credit terms only
  always_comb begin
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy      = 1'b1;
        mem_rd_en = more_to_issue && has_credit && !abort;
      end
      ST_DRAIN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Walk bookkeeping: captured length, issue index, inflight flag, emitted count
  always_comb begin
    num_d      = num_q;
    issue_d    = issue_q;
    emitted_d  = emitted_q;
    inflight_d = mem_rd_en;
    if (start_ok) begin
      num_d     = num_genes;
      issue_d   = '0;
      emitted_d = '0;
    end
    if (mem_rd_en) begin
      issue_d = issue_q + IDX_ONE;
    end
    if (pop) begin
      emitted_d = emitted_q + IDX_ONE;
    end
  end

  // Walk bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q      <= '0;
      issue_q    <= '0;
      emitted_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      num_q      <= num_d;
      issue_q    <= issue_d;
      emitted_q  <= emitted_d;
      inflight_q <= inflight_d;
    end
  end

  assign head          = fifo_empty ? '0 : fifo_head;
  assign mem_rd_addr   = issue_q[IDX_W-1:0];
  assign gene_valid    = !fifo_empty;
  assign gene_enable   = head[GENE_W-1];
  assign gene_in_node  = head[GENE_W-2 -: NODE_W];
  assign gene_out_node = head[WGT_W +: NODE_W];
  assign gene_weight   = head[WGT_W-1:0];
  assign emitted       = emitted_q;

endmodule
